// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults and coordinate types for the VGA pipeline
package vga_pkg;
    localparam int COORD_W      = 10;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               hsync;
        logic               vsync;
        logic               video_on;
        logic               frame_start;
    } vga_out_t;
endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divide-by-4 pixel-rate enable
module vga_pixel_tick (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);
    logic [1:0] div_q;

    // free-running 2-bit divider; the strobe marks its last phase
    always_ff @(posedge clk)
        div_q <= reset ? 2'd0 : div_q + 2'd1;

    assign p_tick = (div_q == 2'd3);
endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator; define VGA_SYNC_OUT_REG_EN for a one-pixel registered output stage
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [COORD_W-1:0] H_MAX    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_MAX    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic               h_wrap, tick;
    vga_out_t           cur;

    vga_pixel_tick u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (tick)
    );

    // next counts, with strobes decoded from them so the flops line up with the new coordinates
    always_comb begin
        h_wrap     = tick && (h_q == H_MAX);
        h_d        = !tick ? h_q : h_wrap ? '0 : h_q + 1'b1;
        v_d        = !h_wrap ? v_q : (v_q == V_MAX) ? '0 : v_q + 1'b1;
        hsync_d    = !(h_d >= HS_FIRST && h_d <= HS_LAST);
        vsync_d    = !(v_d >= VS_FIRST && v_d <= VS_LAST);
        video_on_d = (h_d < H_ACT) && (v_d < V_ACT);
    end

    // counters and registered strobes; reset restarts the frame at (0,0)
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign cur = '{x: h_q, y: v_q, hsync: hsync_q, vsync: vsync_q, video_on: video_on_q,
                   frame_start: tick && (h_q == H_MAX) && (v_q == V_MAX)};
    assign p_tick = tick;

`ifdef VGA_SYNC_OUT_REG_EN
    vga_out_t out_q;

    // one-pixel output stage; frame_start is re-qualified by p_tick so it stays a one-clk pulse
    always_ff @(posedge clk) begin
        if (reset)
            out_q <= '{x: '0, y: '0, hsync: 1'b1, vsync: 1'b1, video_on: 1'b1, frame_start: 1'b0};
        else if (tick)
            out_q <= cur;
    end

    assign {x, y, hsync, vsync, video_on, frame_start} =
        {out_q.x, out_q.y, out_q.hsync, out_q.vsync, out_q.video_on, out_q.frame_start & tick};
`else
    assign {x, y, hsync, vsync, video_on, frame_start} = cur;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: scoreboard bench for vga_sync on a shrunken timing so whole frames fit in a short run
module tb_vga_sync;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 2, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLK = HT * VT * 4;

    typedef struct {
        int x;
        int y;
        int hs;
        int vs;
        int von;
        int pt;
        int fs;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    req;
    } dir_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x, y;
    logic       hsync, vsync, video_on, p_tick, frame_start;

    exp_t sbq[$];
    dir_t dq[$];
    int   checks = 0;
    int   passed = 0;
    int   c = 0;

    always #5 clk = ~clk;

    vga_sync #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .p_tick      (p_tick),
        .frame_start (frame_start)
    );

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endfunction

    function automatic void push(string name, int act, int req);
        dir_t d;
        d.name = name;
        d.act  = act;
        d.req  = req;
        dq.push_back(d);
    endfunction

    // reference: clocks since reset give the pixel index, and from it the expected raster position
    always @(posedge clk) begin
        exp_t e;
        int   n;
        c = reset ? 0 : c + 1;
        n = c / 4;
        e.x   = n % HT;
        e.y   = (n / HT) % VT;
        e.hs  = (e.x >= HA + HF && e.x < HA + HF + HS) ? 0 : 1;
        e.vs  = (e.y >= VA + VF && e.y < VA + VF + VS) ? 0 : 1;
        e.von = (e.x < HA && e.y < VA) ? 1 : 0;
        e.pt  = (c % 4 == 3) ? 1 : 0;
        e.fs  = (e.pt == 1 && e.x == HT - 1 && e.y == VT - 1) ? 1 : 0;
        sbq.push_back(e);
    end

    // monitor: compares every cycle's outputs and any directed measurements
    always @(negedge clk) begin
        exp_t e;
        dir_t d;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            chk(d.name, d.act, d.req);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("x", int'(x), e.x);
            chk("y", int'(y), e.y);
            chk("hsync", int'(hsync), e.hs);
            chk("vsync", int'(vsync), e.vs);
            chk("video_on", int'(video_on), e.von);
            chk("p_tick", int'(p_tick), e.pt);
            chk("frame_start", int'(frame_start), e.fs);
        end
    end

    initial begin
        int first, per, t, fs_n, fs_at, vs_n, hs_n, von_n, cur_n;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (x != 0) begin
                first = i;
                break;
            end
        end
        push("first_adv", first, 4);
        for (int i = 0; i < 8 && !p_tick; i++) @(negedge clk);
        per = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (p_tick) begin
                per = i;
                break;
            end
        end
        push("pt_period", per, 4);
        t = 0;
        while (!frame_start && t < 2 * FRAME_CLK) begin
            @(negedge clk);
            t++;
        end
        push("fs_found", int'(frame_start), 1);
        fs_n = 0; fs_at = -1; vs_n = 0; hs_n = 0; von_n = 0; cur_n = 0;
        for (int i = 1; i <= FRAME_CLK; i++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_n++;
                if (fs_at < 0) fs_at = i;
            end
            if (p_tick) begin
                vs_n  += int'(!vsync);
                hs_n  += int'(!hsync);
                von_n += int'(video_on);
                cur_n += int'(video_on && x == 5 && y == 3);
            end
        end
        push("fs_count", fs_n, 1);
        push("fs_period", fs_at, FRAME_CLK);
        push("vsync_low_px", vs_n, VS * HT);
        push("hsync_low_px", hs_n, HS * VT);
        push("video_on_px", von_n, HA * VA);
        push("cursor_hits", cur_n, 1);
        t = 0;
        while (!(x == 4 && y == 3) && t < FRAME_CLK) begin
            @(negedge clk);
            t++;
        end
        push("mid_found", int'(x == 4 && y == 3), 1);
        reset = 1'b1;
        @(negedge clk);
        push("rst_x", int'(x), 0);
        push("rst_y", int'(y), 0);
        push("rst_hsync", int'(hsync), 1);
        push("rst_vsync", int'(vsync), 1);
        push("rst_fs", int'(frame_start), 0);
        push("rst_pt", int'(p_tick), 0);
        reset = 1'b0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (x != 0) begin
                first = i;
                break;
            end
        end
        push("first_adv_rst", first, 4);
        repeat (200) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
